// File: rtl/hdmi_packet_pkg.sv
// Shared HDMI data-island packet type codes and scheduler state encoding.
// Imported by the packet scheduler and its arbiter.
package hdmi_packet_pkg;
    localparam logic [7:0] PKT_NULL         = 8'h00;
    localparam logic [7:0] PKT_ACR          = 8'h01;
    localparam logic [7:0] PKT_AUDIO_SAMPLE = 8'h02;
    localparam logic [7:0] PKT_AVI          = 8'h82;
    localparam logic [7:0] PKT_SPD          = 8'h83;
    localparam logic [7:0] PKT_AUDIO_IF     = 8'h84;

    typedef enum logic {
        IDLE,
        SEND
    } sched_state_t;
endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with one-hot grant; pointer moves past the
// granted index only when advance is asserted.
module round_robin_arbiter
    import hdmi_packet_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk_pixel,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] req,
    input  logic             advance,
    output logic [WIDTH-1:0] grant
);
    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic          found;
    int            idx;

    always_comb begin
        grant = '0;
        gidx  = ptr;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < WIDTH; i++) begin
            idx = (int'(ptr) + i) % WIDTH;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (gidx == PW'(WIDTH - 1)) ? '0 : gidx + PW'(1);
        end
    end
endmodule

// File: rtl/packet_scheduler.sv
// Data-island packet scheduler: fixed-priority ACR, round-robin
// streams, per-frame InfoFrames, then optional null fill.
module packet_scheduler
    import hdmi_packet_pkg::*;
#(
    parameter int                    NUM_REQ        = 4,
    parameter logic [NUM_REQ*8-1:0]  REQ_TYPE       = {8'h02, 8'h02, 8'h02, 8'h01},
    parameter int                    PACKET_CYCLES  = 32,
    parameter bit                    NULL_FILL      = 1'b1,
    parameter logic [2:0]            INFOFRAME_MASK = 3'b111
) (
    input  logic               clk_pixel,
    input  logic               reset_n,
    input  logic               slot_start,
    input  logic               frame_start,
    input  logic [NUM_REQ-1:0] req,
    input  logic               clear_status,
    output logic [NUM_REQ-1:0] ack,
    output logic               packet_enable,
    output logic [7:0]         packet_type,
    output logic               busy,
    output logic               overrun,
    output logic               infoframe_miss
);
    localparam int CW = $clog2(PACKET_CYCLES + 1);
    localparam int W  = NUM_REQ - 1;
    localparam logic [CW-1:0] TERM = CW'(PACKET_CYCLES);

    sched_state_t        state;
    logic [CW-1:0]       cnt;
    logic [2:0]          pending;
    logic [W-1:0]        rr_grant;
    logic                rr_adv;
    logic                idle;
    logic                sel_valid;
    logic [7:0]          sel_type;
    logic [NUM_REQ-1:0]  sel_ack;
    logic [2:0]          sel_if;

    assign idle = (state == IDLE);

    round_robin_arbiter #(.WIDTH(W)) u_rr (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .req       (req[NUM_REQ-1:1]),
        .advance   (rr_adv),
        .grant     (rr_grant)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_type  = PKT_NULL;
        sel_ack   = '0;
        sel_if    = '0;
        rr_adv    = 1'b0;
        if (req[0]) begin
            sel_valid  = 1'b1;
            sel_type   = REQ_TYPE[7:0];
            sel_ack[0] = 1'b1;
        end else if (|req[NUM_REQ-1:1]) begin
            sel_valid = 1'b1;
            rr_adv    = slot_start && idle;
            for (int i = 1; i < NUM_REQ; i++) begin
                if (rr_grant[i-1]) begin
                    sel_ack[i] = 1'b1;
                    sel_type   = REQ_TYPE[i*8 +: 8];
                end
            end
        end else if (pending[0]) begin
            sel_valid = 1'b1;
            sel_type  = PKT_AVI;
            sel_if    = 3'b001;
        end else if (pending[1]) begin
            sel_valid = 1'b1;
            sel_type  = PKT_AUDIO_IF;
            sel_if    = 3'b010;
        end else if (pending[2]) begin
            sel_valid = 1'b1;
            sel_type  = PKT_SPD;
            sel_if    = 3'b100;
        end else if (NULL_FILL) begin
            sel_valid = 1'b1;
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            ack            <= '0;
            packet_enable  <= 1'b0;
            packet_type    <= PKT_NULL;
            busy           <= 1'b0;
            overrun        <= 1'b0;
            infoframe_miss <= 1'b0;
            pending        <= '0;
        end else begin
            ack           <= '0;
            packet_enable <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (slot_start && sel_valid) begin
                        state         <= SEND;
                        cnt           <= CW'(1);
                        ack           <= sel_ack;
                        packet_enable <= 1'b1;
                        packet_type   <= sel_type;
                        busy          <= 1'b1;
                    end
                end
                SEND: begin
                    if (cnt == TERM) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        busy        <= 1'b0;
                        packet_type <= PKT_NULL;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase

            if (slot_start && !idle) overrun <= 1'b1;
            else if (clear_status)   overrun <= 1'b0;

            // A frame_start reload overrides a same-cycle grant clear.
            if (frame_start)                pending <= INFOFRAME_MASK;
            else if (slot_start && idle)    pending <= pending & ~sel_if;

            if (frame_start && |pending) infoframe_miss <= 1'b1;
            else if (clear_status)       infoframe_miss <= 1'b0;
        end
    end
endmodule

// File: tb/tb_packet_scheduler.sv
// Directed and randomized bench for packet_scheduler against a
// cycle-level behavioural model of the scheduling rules.
module tb_packet_scheduler;
    localparam int N  = 4;
    localparam int PC = 32;

    logic         clk_pixel = 1'b0;
    logic         reset_n = 1'b0;
    logic         slot_start = 1'b0;
    logic         frame_start = 1'b0;
    logic         clear_status = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] ack;
    logic         packet_enable;
    logic [7:0]   packet_type;
    logic         busy;
    logic         overrun;
    logic         infoframe_miss;

    int checks = 0;
    int errors = 0;

    logic [7:0] tt [N]   = '{8'h01, 8'h02, 8'h02, 8'h02};
    logic [7:0] ift [3]  = '{8'h82, 8'h84, 8'h83};

    int         m_rem;
    int         m_ptr;
    logic [7:0] m_type;
    logic [N-1:0] m_ack;
    logic       m_pe;
    logic       m_pend [3];
    logic       m_ovr;
    logic       m_miss;

    packet_scheduler dut (
        .clk_pixel      (clk_pixel),
        .reset_n        (reset_n),
        .slot_start     (slot_start),
        .frame_start    (frame_start),
        .req            (req),
        .clear_status   (clear_status),
        .ack            (ack),
        .packet_enable  (packet_enable),
        .packet_type    (packet_type),
        .busy           (busy),
        .overrun        (overrun),
        .infoframe_miss (infoframe_miss)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_ack"},  32'(ack),            32'(m_ack));
        check({tag, "_pe"},   32'(packet_enable),  32'(m_pe));
        check({tag, "_type"}, 32'(packet_type),    32'(m_type));
        check({tag, "_busy"}, 32'(busy),           32'(m_rem > 0));
        check({tag, "_ovr"},  32'(overrun),        32'(m_ovr));
        check({tag, "_miss"}, 32'(infoframe_miss), 32'(m_miss));
    endtask

    task automatic model_reset();
        m_rem  = 0;
        m_ptr  = 1;
        m_type = 8'h00;
        m_ack  = '0;
        m_pe   = 1'b0;
        m_ovr  = 1'b0;
        m_miss = 1'b0;
        for (int i = 0; i < 3; i++) m_pend[i] = 1'b0;
    endtask

    // Expected outputs after one clock edge with the given inputs.
    task automatic model_edge(input logic s, input logic f,
                              input logic clr, input logic [N-1:0] r);
        bit   idle;
        bit   got;
        bit   any_pend;
        int   gif;
        idle     = (m_rem == 0);
        got      = 0;
        gif      = -1;
        any_pend = m_pend[0] | m_pend[1] | m_pend[2];
        m_ack    = '0;
        m_pe     = 1'b0;
        if (s && idle) begin
            if (r[0]) begin
                got = 1; m_type = tt[0]; m_ack[0] = 1'b1;
            end else if (|r[N-1:1]) begin
                for (int k = 0; k < N - 1; k++) begin
                    int idx;
                    idx = 1 + ((m_ptr - 1 + k) % (N - 1));
                    if (!got && r[idx]) begin
                        got = 1; m_type = tt[idx]; m_ack[idx] = 1'b1;
                        m_ptr = (idx % (N - 1)) + 1;
                    end
                end
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if (!got && m_pend[k]) begin
                        got = 1; m_type = ift[k]; gif = k;
                    end
                end
                if (!got) begin
                    got = 1; m_type = 8'h00;
                end
            end
            if (got) begin
                m_rem = PC;
                m_pe  = 1'b1;
            end
        end else if (!idle) begin
            m_rem--;
            if (m_rem == 0) m_type = 8'h00;
        end
        if (s && !idle) m_ovr = 1'b1;
        else if (clr)   m_ovr = 1'b0;
        if (f && any_pend) m_miss = 1'b1;
        else if (clr)      m_miss = 1'b0;
        if (gif >= 0) m_pend[gif] = 1'b0;
        if (f) for (int k = 0; k < 3; k++) m_pend[k] = 1'b1;
    endtask

    task automatic step(input string tag, input logic s, input logic f,
                        input logic clr, input logic [N-1:0] r);
        slot_start   = s;
        frame_start  = f;
        clear_status = clr;
        req          = r;
        @(posedge clk_pixel);
        model_edge(s, f, clr, r);
        #1;
        check_all(tag);
        slot_start   = 1'b0;
        frame_start  = 1'b0;
        clear_status = 1'b0;
    endtask

    task automatic idle_steps(input string tag, input int n,
                              input logic [N-1:0] r);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, r);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk_pixel);
        #1;
        check_all(tag);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        do_reset("reset");

        // InfoFrames in AVI, audio, SPD order, then null.
        step("if_frame", 1'b0, 1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            step("if_slot", 1'b1, 1'b0, 1'b0, 4'b0000);
            idle_steps("if_wait", 39, 4'b0000);
        end

        // req[0] always wins.
        for (int i = 0; i < 6; i++) begin
            step("acr_slot", 1'b1, 1'b0, 1'b0, 4'b1111);
            idle_steps("acr_wait", 39, 4'b1111);
        end

        // Round-robin among the streaming requesters.
        for (int i = 0; i < 6; i++) begin
            step("rr_slot", 1'b1, 1'b0, 1'b0, 4'b1110);
            idle_steps("rr_wait", 39, 4'b1110);
        end

        // Slot arriving mid-packet is ignored and flags overrun.
        step("ovr_slot0", 1'b1, 1'b0, 1'b0, 4'b0100);
        idle_steps("ovr_run", 9, 4'b0100);
        step("ovr_slot1", 1'b1, 1'b0, 1'b0, 4'b0100);
        idle_steps("ovr_run2", 25, 4'b0000);
        step("ovr_clr", 1'b0, 1'b0, 1'b1, 4'b0000);
        idle_steps("ovr_done", 5, 4'b0000);

        // Missed InfoFrames and coincident frame/slot.
        step("miss_f1", 1'b0, 1'b1, 1'b0, 4'b0000);
        idle_steps("miss_gap", 3, 4'b0000);
        step("miss_f2", 1'b0, 1'b1, 1'b0, 4'b0000);
        step("miss_clr", 1'b0, 1'b0, 1'b1, 4'b0000);
        step("coin", 1'b1, 1'b1, 1'b0, 4'b0000);
        idle_steps("coin_run", 33, 4'b0000);
        step("coin_avi", 1'b1, 1'b0, 1'b0, 4'b0000);
        idle_steps("coin_run2", 33, 4'b0000);
        step("clr_evt", 1'b1, 1'b1, 1'b1, 4'b0000);
        idle_steps("clr_run", 3, 4'b0000);
        step("clr_evt2", 1'b1, 1'b0, 1'b1, 4'b0000);
        idle_steps("clr_run2", 32, 4'b0000);

        // Reset mid-packet.
        step("rst_slot", 1'b1, 1'b0, 1'b0, 4'b0010);
        idle_steps("rst_run", 14, 4'b0010);
        #2;
        do_reset("rst_mid");
        step("rst_next", 1'b1, 1'b0, 1'b0, 4'b0000);
        idle_steps("rst_next_run", 34, 4'b0000);

        // Randomized traffic.
        begin
            logic [N-1:0] r;
            r = '0;
            for (int i = 0; i < 6000; i++) begin
                if ($urandom_range(0, 63) == 0) r = N'($urandom);
                step("rnd",
                     $urandom_range(0, 15) == 0,
                     $urandom_range(0, 299) == 0,
                     $urandom_range(0, 49) == 0,
                     r);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/packet_scheduler.md
PACKET_SCHEDULER -- requirements
Module: packet_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of streaming requesters, at least 2.
REQ-002 Parameter REQ_TYPE, default {8'h02, 8'h02, 8'h02, 8'h01} (index 0 rightmost): packed NUM_REQ x 8 packet types, one per requester.
REQ-003 Parameter PACKET_CYCLES, default 32: pixel clocks per packet.
REQ-004 Parameter NULL_FILL, default 1: send a null packet (type 8'h00) when nothing is pending.
REQ-005 Parameter INFOFRAME_MASK, default 3'b111: enables per-frame AVI (bit 0, 8'h82), audio (bit 1, 8'h84) and SPD (bit 2, 8'h83) InfoFrames.
REQ-006 clk_pixel  in  1  pixel clock; the single clock domain.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 slot_start  in  1  one-cycle pulse; a data-island packet slot begins next cycle.
REQ-009 frame_start  in  1  one-cycle pulse at vsync start.
REQ-010 req  in  NUM_REQ  level requests from packet generators.
REQ-011 clear_status  in  1  synchronous clear of sticky flags.
REQ-012 ack  out  NUM_REQ  one-hot, one-cycle grant pulse.
REQ-013 packet_enable  out  1  one-cycle pulse starting a packet; drives the packet picker.
REQ-014 packet_type  out  8  selected type, held for the whole packet.
REQ-015 busy  out  1  high while a packet is in flight.
REQ-016 overrun  out  1  sticky: slot_start arrived while busy.
REQ-017 infoframe_miss  out  1  sticky: frame_start arrived with an InfoFrame still pending.

Function
REQ-018 States: IDLE and SEND. IDLE->SEND on slot_start when a packet is selected; SEND->IDLE after PACKET_CYCLES cycles.
REQ-019 Selection priority on slot_start, using pre-cycle state: req[0] first (fixed, clock regeneration); then req[NUM_REQ-1:1] in round-robin; then pending InfoFrames in order AVI, audio, SPD; then null packet if NULL_FILL=1.
REQ-020 With nothing pending and NULL_FILL=0, the block stays in IDLE and issues no pulse.
REQ-021 Latency: slot_start at cycle t -> packet_enable, packet_type and ack (for a requester grant) all valid at t+1.
REQ-022 packet_enable is high only at t+1; packet_type is stable from t+1 through t+PACKET_CYCLES.
REQ-023 busy is high from t+1 through t+PACKET_CYCLES inclusive.
REQ-024 The round-robin pointer moves past the granted index only on a grant to req[NUM_REQ-1:1].
REQ-025 slot_start while busy is ignored (no ack, no packet_type change) and sets overrun.
REQ-026 Slot counter is ceil(log2(PACKET_CYCLES+1)) bits and saturates, with no wrap-around beyond the terminal count.
REQ-027 frame_start sets pending bits to INFOFRAME_MASK; it first sets infoframe_miss if any pending bit is still set.
REQ-028 On an InfoFrame grant, its pending bit clears at t+1.
REQ-029 frame_start coincident with slot_start: arbitration uses the old pending bits, then the set takes effect. A bit granted in that same cycle ends up set.
REQ-030 clear_status coincident with a new overrun or miss event: the event wins and the flag is set.
REQ-031 packet_type is 8'h00 whenever the block is idle.

Reset
REQ-032 reset_n low asynchronously forces: state IDLE, counter 0, ack 0, packet_enable 0, packet_type 8'h00, busy 0, overrun 0, infoframe_miss 0, round-robin pointer at index 1, InfoFrame pending bits 0.
REQ-033 Reset mid-packet aborts the packet; the first slot_start after deassertion is arbitrated normally.

Structure
REQ-034 Shared package hdmi_packet_pkg holds the packet type constants: NULL 8'h00, ACR 8'h01, AUDIO_SAMPLE 8'h02, AVI 8'h82, SPD 8'h83, AUDIO_IF 8'h84.
REQ-035 Sub-module round_robin_arbiter (parameterized width, request and advance inputs, one-hot grant output) implements the req[NUM_REQ-1:1] rotation.

Verification
REQ-036 After reset, frame_start, then 4 slot_starts 40 cycles apart with req=0 -> types 82, 84, 83, 00; each packet_enable pulse is 1 cycle; busy is 32 cycles.
REQ-037 req=4'b1111 held, 6 slots -> types 01 every slot; ack=0001 each time; the round-robin pointer does not move.
REQ-038 req=4'b1110 held, 6 slots -> ack sequence 0010, 0100, 1000, 0010, 0100, 1000.
REQ-039 slot_start 10 cycles into a packet -> no ack; packet_type unchanged; overrun=1 until clear_status.
REQ-040 Two frame_starts with no slots between -> infoframe_miss=1; frame_start and slot_start in the same cycle -> AVI is sent and AVI pending ends up set.
REQ-041 reset_n low at cycle 15 of a packet -> all outputs 0 immediately; the next slot_start gives a normal 32-cycle packet.
